// File: rtl/child_palette_encoder_if.sv
// Pixel stream, palette-table write port and error-count bundle for child_palette_encoder.
// The master modport is the side that sources pixels and table writes; the slave is the encoder.
interface child_palette_encoder_if;
    logic        in_valid;
    logic [23:0] in_rgb;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_index;
    logic        out_mismatch;
    logic        out_last;
    logic        out_ready;
    logic        tbl_we;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_gb;
    logic        err_clr;
    logic [15:0] err_count;

    modport master (
        output in_valid, in_rgb, out_ready, tbl_we, tbl_addr, tbl_gb, err_clr,
        input  in_ready, out_valid, out_index, out_mismatch, out_last, err_count
    );

    modport slave (
        input  in_valid, in_rgb, out_ready, tbl_we, tbl_addr, tbl_gb, err_clr,
        output in_ready, out_valid, out_index, out_mismatch, out_last, err_count
    );
endinterface

// File: rtl/child_palette_encoder.sv
// Two-stage palette encoder: index = red byte, optional G/B check against a 256x16 table.
// Define CHILD_PAL_CHECK_EN to build the table, compare and error counter.
module child_palette_encoder #(
    parameter int unsigned FRAME_PIXELS = 4096
) (
    input logic                    clk,
    input logic                    rst_n,
    child_palette_encoder_if.slave bus
);
    localparam logic [15:0] LastPixel = 16'(FRAME_PIXELS - 1);

    logic        advance;
    logic        xfer;
    logic        s1_valid_q;
    logic [23:0] s1_rgb_q;
    logic        s2_valid_q;
    logic [23:0] s2_rgb_q;
    logic [15:0] pix_cnt_q;
    logic [15:0] pix_cnt_d;
    logic        mismatch;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign advance      = !s2_valid_q || bus.out_ready;
    assign xfer         = s2_valid_q && bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= 24'h0;
            s2_valid_q <= 1'b0;
            s2_rgb_q   <= 24'h0;
        end else if (advance) begin
            s1_valid_q <= bus.in_valid;
            s1_rgb_q   <= bus.in_rgb;
            s2_valid_q <= s1_valid_q;
            s2_rgb_q   <= s1_rgb_q;
        end
    end

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (xfer) begin
            pix_cnt_d = bus.out_last ? 16'h0 : pix_cnt_q + 16'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q <= 16'h0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign bus.out_valid    = s2_valid_q;
    assign bus.out_index    = s2_rgb_q[23:16];
    assign bus.out_last     = s2_valid_q && (pix_cnt_q == LastPixel);
    assign bus.out_mismatch = s2_valid_q && mismatch;

`ifdef CHILD_PAL_CHECK_EN
    logic [15:0] tbl_mem [256];
    logic [15:0] rd_q;
    logic [15:0] err_q;
    logic [15:0] err_d;

    // Table is never reset; a same-cycle write is seen by the read one cycle later.
    always_ff @(posedge clk) begin
        if (bus.tbl_we) begin
            tbl_mem[bus.tbl_addr] <= bus.tbl_gb;
        end
        if (advance) begin
            rd_q <= tbl_mem[s1_rgb_q[23:16]];
        end
    end

    assign mismatch = (s2_rgb_q[15:0] != rd_q);

    always_comb begin
        err_d = err_q;
        if (bus.err_clr) begin
            err_d = 16'h0;
        end else if (xfer && bus.out_mismatch && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 16'h0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_count = err_q;
`else
    logic unused_cfg;

    assign mismatch      = 1'b0;
    assign bus.err_count = 16'h0;
    assign unused_cfg    = ^{bus.tbl_we, bus.tbl_addr, bus.tbl_gb, bus.err_clr, s2_rgb_q[15:0]};
`endif
endmodule

// File: doc/child_palette_encoder.md
CHILD_PALETTE_ENCODER -- requirements
Module: child_palette_encoder

Interface
REQ-001 Parameter FRAME_PIXELS, default 4096, number of pixels per frame (64x64 sprite); legal range 2..65535.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_rgb carries a pixel.
REQ-005 in_rgb  input  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-006 in_ready  output  1  encoder accepts in_rgb this cycle.
REQ-007 out_valid  output  1  out_index carries an encoded pixel.
REQ-008 out_index  output  8  palette index; equals the pixel's red byte.
REQ-009 out_mismatch  output  1  pixel G/B differ from the table entry for its index; qualified by out_valid.
REQ-010 out_last  output  1  final pixel of a frame; qualified by out_valid.
REQ-011 out_ready  input  1  downstream accepts out_index this cycle.
REQ-012 tbl_we  input  1  palette table write strobe.
REQ-013 tbl_addr  input  8  palette table write address.
REQ-014 tbl_gb  input  16  palette table write data {G,B}.
REQ-015 err_clr  input  1  clears err_count.
REQ-016 err_count  output  16  saturating count of mismatched output beats.

Function
REQ-017 advance = !out_valid || out_ready; in_ready SHALL equal advance combinationally.
REQ-018 Input beat accepted when in_valid && in_ready; output beat transferred when out_valid && out_ready.
REQ-019 Two-stage pipeline: S1 registers pixel and issues synchronous table read; S2 compares and drives outputs; both stages load only when advance=1.
REQ-020 Latency: an accepted pixel SHALL appear on outputs 2 cycles later when out_ready is held high.
REQ-021 When advance=0, S1 and S2 contents and all outputs SHALL hold unchanged; no pixel dropped or duplicated.
REQ-022 S1 valid loads in_valid when advance=1; S2 valid (out_valid) loads S1 valid when advance=1; sustained throughput one pixel/cycle.
REQ-023 out_index = R byte of the S2 pixel; out_mismatch = (S2 {G,B} != table entry read at index R).
REQ-024 Table: 256 x 16 bits, contents undefined after power-up and unaffected by Reset_n.
REQ-025 Table write and S1 read of the same address in one cycle: read returns the old data; new data visible from the next cycle.
REQ-026 Pixel counter (16 bits) increments on each output transfer; out_last = out_valid && (counter == FRAME_PIXELS-1); transfer with out_last wraps counter to 0.
REQ-027 err_count increments by 1 on each output transfer with out_mismatch=1; saturates at 16'hFFFF.
REQ-028 err_clr=1 sets err_count to 0 next cycle; clear wins over a simultaneous increment.
REQ-029 Stalled beats (out_valid && !out_ready) SHALL NOT change counters.

Reset
REQ-030 Reset_n low asynchronously clears S1 valid, out_valid, pixel counter, err_count; out_index, out_mismatch, out_last SHALL read 0.
REQ-031 Reset mid-frame discards in-flight pixels; the first transfer after release is pixel 0 of a new frame.
REQ-032 in_ready SHALL be 1 during and immediately after reset (out_valid=0).

Configuration
REQ-033 Macro CHILD_PAL_CHECK_EN: when defined, table, compare, and err_count logic are compiled in as specified.
REQ-034 Without CHILD_PAL_CHECK_EN: no table storage; tbl_* and err_clr ignored; out_mismatch tied 0; err_count tied 0; pipeline, latency, and out_last unchanged.

Verification
REQ-035 Load tbl[8'h8b]=16'h6c28; stream 24'h8b6c28, out_ready=1 -> out_index=8'h8b, out_mismatch=0 two cycles after acceptance; err_count=0.
REQ-036 Load tbl[8'hff]=16'hffff; stream 24'hfffffe -> out_mismatch=1, err_count=1; 70000 further mismatches -> err_count=16'hFFFF.
REQ-037 Stream 4096 pixels with out_ready random 50% -> exactly 4096 transfers in order, out_last only on transfer 4096; pixel 4097 has out_last=0.
REQ-038 Hold out_ready=0 for 5 cycles with both stages full -> in_ready=0, outputs stable; release -> pending pixels delivered in order, none lost.
REQ-039 Write tbl[8'h76]=16'h4f00 in the same cycle S1 reads index 8'h76 (old 16'h0000) with pixel 24'h764f00 -> mismatch=1; repeat the pixel next cycle -> mismatch=0.
REQ-040 Assert Reset_n low at pixel 100 of a frame -> outputs 0, err_count 0; after release, out_last on the 4096th subsequent transfer.
